// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming K x K x CHANNEL sliding-window generator with zero padding and stride.
// Optional CONV_WIN_CNT_EN adds per-frame handshaken-window and stall counters.
module conv_window_gen #(
  parameter int WIDTH    = 128,
  parameter int HEIGHT   = 128,
  parameter int CHANNEL  = 3,
  parameter int BITWIDTH = 16,
  parameter int K        = 3,
  parameter int STRIDE   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic [CHANNEL*BITWIDTH-1:0]     i_data,
  input  logic                            i_valid,
  output logic                            o_ready,
  output logic [K*K*CHANNEL*BITWIDTH-1:0] o_win,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [$clog2(HEIGHT)-1:0]       o_row,
  output logic [$clog2(WIDTH)-1:0]        o_col,
  output logic                            o_busy,
  output logic                            o_done
`ifdef CONV_WIN_CNT_EN
  ,
  output logic [31:0]                     o_win_cnt,
  output logic [31:0]                     o_stall_cnt
`endif
);

  localparam int PAD = (K - 1) / 2;
  localparam int PW  = CHANNEL * BITWIDTH;
  localparam int WW  = K * K * PW;
  localparam int RW  = $clog2(HEIGHT);
  localparam int CW  = $clog2(WIDTH);
  localparam int LBD = WIDTH + PAD;
  localparam int VRW = $clog2(HEIGHT + PAD);
  localparam int VCW = $clog2(LBD);

  localparam logic [VRW-1:0] VR_IMG  = VRW'(HEIGHT);
  localparam logic [VCW-1:0] VC_IMG  = VCW'(WIDTH);
  localparam logic [VRW-1:0] VR_LAST = VRW'(HEIGHT - 1 + PAD);
  localparam logic [VCW-1:0] VC_LAST = VCW'(WIDTH - 1 + PAD);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [VRW-1:0] vr_q, vr_d;
  logic [VCW-1:0] vc_q, vc_d;
  logic [WW-1:0]  owin_q, owin_d;
  logic           valid_q, valid_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  col_q, col_d;
  logic           done_q, done_d;

  logic [PW-1:0]  win_q   [K][K];
  logic [PW-1:0]  winNext [K][K];
  logic [PW-1:0]  lb_q    [K-1][LBD];
  logic [PW-1:0]  column  [K];
  logic [WW-1:0]  owinNext;
  logic           inImage, canAdvance, step, emit, lastPos;
  int             centreR, centreC;

  // Column entering the window: K-1 older rows from the line buffers, newest row from the input (zero in padding).
  always_comb begin
    inImage    = (vr_q < VR_IMG) && (vc_q < VC_IMG);
    canAdvance = !valid_q || i_ready;
    step       = (state_q == RUN) && canAdvance && (!inImage || i_valid);
    lastPos    = (vr_q == VR_LAST) && (vc_q == VC_LAST);
    for (int dr = 0; dr < K - 1; dr++) column[dr] = lb_q[dr][vc_q];
    column[K-1] = inImage ? i_data : '0;
    for (int dr = 0; dr < K; dr++) begin
      for (int dc = 0; dc < K - 1; dc++) winNext[dr][dc] = win_q[dr][dc+1];
      winNext[dr][K-1] = column[dr];
    end
    centreR = int'(vr_q) - PAD;
    centreC = int'(vc_q) - PAD;
    emit = step && (centreR >= 0) && (centreC >= 0) &&
           ((centreR % STRIDE) == 0) && ((centreC % STRIDE) == 0);
    owinNext = '0;
    for (int dr = 0; dr < K; dr++) begin
      for (int dc = 0; dc < K; dc++) begin
        if ((centreR - PAD + dr >= 0) && (centreR - PAD + dr < HEIGHT) &&
            (centreC - PAD + dc >= 0) && (centreC - PAD + dc < WIDTH))
          owinNext[(dr*K+dc)*PW +: PW] = winNext[dr][dc];
      end
    end
  end

  // Scan FSM: DRAIN waits only for the final window, which cannot be overwritten once stepping has stopped.
  always_comb begin
    state_d = state_q;
    vr_d    = vr_q;
    vc_d    = vc_q;
    valid_d = valid_q;
    owin_d  = owin_q;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;
    if (valid_q && i_ready) valid_d = 1'b0;
    if (emit) begin
      valid_d = 1'b1;
      owin_d  = owinNext;
      row_d   = RW'(centreR);
      col_d   = CW'(centreC);
    end
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RUN;
          vr_d    = '0;
          vc_d    = '0;
        end
      end
      RUN: begin
        if (step) begin
          if (lastPos) begin
            state_d = DRAIN;
            vr_d    = '0;
            vc_d    = '0;
          end else if (vc_q == VC_LAST) begin
            vc_d = '0;
            vr_d = vr_q + VRW'(1);
          end else begin
            vc_d = vc_q + VCW'(1);
          end
        end
      end
      DRAIN: begin
        if (canAdvance) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vr_q    <= '0;
      vc_q    <= '0;
      owin_q  <= '0;
      valid_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vr_q    <= vr_d;
      vc_q    <= vc_d;
      owin_q  <= owin_d;
      valid_q <= valid_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
    end
  end

  // Each step shifts the window left and pushes the column up one line buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int dr = 0; dr < K; dr++)
        for (int dc = 0; dc < K; dc++) win_q[dr][dc] <= '0;
      for (int j = 0; j < K - 1; j++)
        for (int e = 0; e < LBD; e++) lb_q[j][e] <= '0;
    end else if (step) begin
      for (int dr = 0; dr < K; dr++)
        for (int dc = 0; dc < K; dc++) win_q[dr][dc] <= winNext[dr][dc];
      for (int j = 0; j < K - 1; j++) lb_q[j][vc_q] <= column[j+1];
    end
  end

  assign o_ready = (state_q == RUN) && inImage && canAdvance;
  assign o_win   = owin_q;
  assign o_valid = valid_q;
  assign o_row   = row_q;
  assign o_col   = col_q;
  assign o_busy  = (state_q != IDLE);
  assign o_done  = done_q;

`ifdef CONV_WIN_CNT_EN
  logic [31:0] winCnt_q, stallCnt_q;
  logic        startAcc;

  assign startAcc = (state_q == IDLE) && i_start;

  // Saturating per-frame counters, cleared when a new frame is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winCnt_q   <= '0;
      stallCnt_q <= '0;
    end else if (startAcc) begin
      winCnt_q   <= '0;
      stallCnt_q <= '0;
    end else begin
      if (valid_q && i_ready && (winCnt_q != '1)) winCnt_q <= winCnt_q + 32'd1;
      if (valid_q && !i_ready && (stallCnt_q != '1)) stallCnt_q <= stallCnt_q + 32'd1;
    end
  end

  assign o_win_cnt   = winCnt_q;
  assign o_stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: three 4x4 K=3 instances (C=1 S=1, C=1 S=2, C=3 S=1) driven one at a time.
// Build with CONV_WIN_CNT_EN to also check the window/stall counters.
module tb_conv_window_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic         startCmd, validIn, readyIn;
  logic [47:0]  dataIn;
  int           sel;

  logic         aReady, aValid, aBusy, aDone, bReady, bValid, bBusy, bDone, cReady, cValid, cBusy, cDone;
  logic [143:0] aWin, bWin;
  logic [431:0] cWin;
  logic [1:0]   aRow, aCol, bRow, bCol, cRow, cCol;

  logic         oReady, oValid, oBusy, oDone;
  logic [431:0] oWin;
  logic [1:0]   oRow, oCol;

  logic [431:0] capWin [16];
  int           capRow [16];
  int           capCol [16];
  int           nCap;
  int           total = 0;
  int           bad = 0;

  typedef struct {
    int s;
    int r;
    int c;
    int ch;
    int v [9];
  } spot_t;
  localparam int NSPOT = 10;
  spot_t spots [NSPOT];

  always #5 clk = ~clk;

`ifdef CONV_WIN_CNT_EN
  logic [31:0] aWinCnt, aStallCnt, bWinCnt, bStallCnt, cWinCnt, cStallCnt, oWinCnt, oStallCnt;
`endif

  conv_window_gen #(.WIDTH(4), .HEIGHT(4), .CHANNEL(1), .BITWIDTH(16), .K(3), .STRIDE(1)) dutA (
    .clk(clk), .rst(rst), .i_start(startCmd && sel == 0), .i_data(dataIn[15:0]), .i_valid(validIn),
    .o_ready(aReady), .o_win(aWin), .o_valid(aValid), .i_ready(readyIn), .o_row(aRow), .o_col(aCol),
    .o_busy(aBusy), .o_done(aDone)
`ifdef CONV_WIN_CNT_EN
    , .o_win_cnt(aWinCnt), .o_stall_cnt(aStallCnt)
`endif
  );

  conv_window_gen #(.WIDTH(4), .HEIGHT(4), .CHANNEL(1), .BITWIDTH(16), .K(3), .STRIDE(2)) dutB (
    .clk(clk), .rst(rst), .i_start(startCmd && sel == 1), .i_data(dataIn[15:0]), .i_valid(validIn),
    .o_ready(bReady), .o_win(bWin), .o_valid(bValid), .i_ready(readyIn), .o_row(bRow), .o_col(bCol),
    .o_busy(bBusy), .o_done(bDone)
`ifdef CONV_WIN_CNT_EN
    , .o_win_cnt(bWinCnt), .o_stall_cnt(bStallCnt)
`endif
  );

  conv_window_gen #(.WIDTH(4), .HEIGHT(4), .CHANNEL(3), .BITWIDTH(16), .K(3), .STRIDE(1)) dutC (
    .clk(clk), .rst(rst), .i_start(startCmd && sel == 2), .i_data(dataIn), .i_valid(validIn),
    .o_ready(cReady), .o_win(cWin), .o_valid(cValid), .i_ready(readyIn), .o_row(cRow), .o_col(cCol),
    .o_busy(cBusy), .o_done(cDone)
`ifdef CONV_WIN_CNT_EN
    , .o_win_cnt(cWinCnt), .o_stall_cnt(cStallCnt)
`endif
  );

  // Present the selected instance's outputs on one set of observation signals.
  always_comb begin
    oReady = aReady; oValid = aValid; oBusy = aBusy; oDone = aDone;
    oWin = {288'b0, aWin}; oRow = aRow; oCol = aCol;
`ifdef CONV_WIN_CNT_EN
    oWinCnt = aWinCnt; oStallCnt = aStallCnt;
`endif
    if (sel == 1) begin
      oReady = bReady; oValid = bValid; oBusy = bBusy; oDone = bDone;
      oWin = {288'b0, bWin}; oRow = bRow; oCol = bCol;
`ifdef CONV_WIN_CNT_EN
      oWinCnt = bWinCnt; oStallCnt = bStallCnt;
`endif
    end else if (sel == 2) begin
      oReady = cReady; oValid = cValid; oBusy = cBusy; oDone = cDone;
      oWin = cWin; oRow = cRow; oCol = cCol;
`ifdef CONV_WIN_CNT_EN
      oWinCnt = cWinCnt; oStallCnt = cStallCnt;
`endif
    end
  end

  function automatic logic [47:0] pixelData(input int p);
    logic [47:0] d;
    for (int ch = 0; ch < 3; ch++) d[ch*16 +: 16] = 16'(100 * ch + p + 1);
    return d;
  endfunction

  // Reference window: element (dr,dc,ch) is 100*ch + pixel(row,col), zero outside the 4x4 frame.
  function automatic logic [431:0] expWin(input int r, input int c, input int nch);
    logic [431:0] w;
    int sr, sc;
    w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        for (int ch = 0; ch < nch; ch++) begin
          sr = r - 1 + dr;
          sc = c - 1 + dc;
          if (sr >= 0 && sr < 4 && sc >= 0 && sc < 4)
            w[((dr*3+dc)*nch+ch)*16 +: 16] = 16'(100 * ch + sr * 4 + sc + 1);
        end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [447:0] act, input logic [447:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Run one frame on instance s; stopBeats>0 returns early right after that many pixels were accepted.
  task automatic applyStimulus(input int s, input bit randReady, input int gap, input int stopBeats);
    int pix, gapCnt, lastHs, stalls;
    bit prevStall, doneSeen;
    logic [431:0] heldWin;
    logic [3:0] heldPos;
    sel = s; nCap = 0; pix = 0; gapCnt = 0; lastHs = -10; stalls = 0;
    prevStall = 1'b0; doneSeen = 1'b0; heldWin = '0; heldPos = '0;
    @(posedge clk); #1 startCmd = 1'b1;
    @(posedge clk); #1 startCmd = 1'b0;
    checkOutput("busy_after_start", 448'(oBusy), 448'(1));
`ifdef CONV_WIN_CNT_EN
    if (s == 0) checkOutput("cnt_cleared_by_start", 448'({oWinCnt, oStallCnt}), 448'(0));
`endif
    for (int cyc = 0; cyc < 600 && !doneSeen; cyc++) begin
      validIn = (pix < 16) && (gapCnt == 0);
      dataIn  = pixelData(pix);
      readyIn = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (prevStall)
        checkOutput("held_window", 448'({oValid, oRow, oCol, oWin}), 448'({1'b1, heldPos, heldWin}));
      prevStall = oValid && !readyIn;
      if (prevStall) begin
        stalls++;
        heldWin = oWin;
        heldPos = {oRow, oCol};
      end
      if (oValid && readyIn) begin
        if (nCap < 16) begin
          capWin[nCap] = oWin;
          capRow[nCap] = int'(oRow);
          capCol[nCap] = int'(oCol);
        end
        nCap++;
        lastHs = cyc;
      end
      if (validIn && oReady) begin
        pix++;
        gapCnt = gap;
      end else if (gapCnt > 0) begin
        gapCnt--;
      end
      if (oDone) begin
        doneSeen = 1'b1;
        if (s != 1) checkOutput("done_one_cycle_after_last", 448'(cyc), 448'(lastHs + 1));
`ifdef CONV_WIN_CNT_EN
        if (s == 0) begin
          checkOutput("win_cnt_at_done", 448'(oWinCnt), 448'(16));
          checkOutput("stall_cnt_at_done", 448'(oStallCnt), 448'(stalls));
        end
`endif
      end
      if (stopBeats > 0 && pix == stopBeats) return;
      @(posedge clk); #1;
    end
    if (!doneSeen) checkOutput("done_within_budget", 448'(0), 448'(1));
  endtask

  task automatic checkFrame(input int s);
    int nch, stride, per;
    nch = (s == 2) ? 3 : 1;
    stride = (s == 1) ? 2 : 1;
    per = 4 / stride;
    checkOutput("window_count", 448'(nCap), 448'(per * per));
    for (int i = 0; i < 16 && i < nCap; i++) begin
      checkOutput($sformatf("pos_%0d", i), 448'({capRow[i], capCol[i]}),
                  448'({(i / per) * stride, (i % per) * stride}));
      checkOutput($sformatf("win_%0d", i), 448'(capWin[i]),
                  448'(expWin((i / per) * stride, (i % per) * stride, nch)));
    end
  endtask

  task automatic checkSpots(input int s);
    int nch, hit;
    logic [143:0] act, req;
    nch = (s == 2) ? 3 : 1;
    for (int t = 0; t < NSPOT; t++) begin
      if (spots[t].s == s) begin
        hit = -1;
        for (int i = 0; i < 16 && i < nCap; i++)
          if (capRow[i] == spots[t].r && capCol[i] == spots[t].c) hit = i;
        act = '0;
        req = '0;
        for (int e = 0; e < 9; e++) begin
          req[e*16 +: 16] = 16'(spots[t].v[e]);
          if (hit >= 0) act[e*16 +: 16] = capWin[hit][(e*nch+spots[t].ch)*16 +: 16];
        end
        checkOutput($sformatf("spot_s%0d_r%0d_c%0d_ch%0d", s, spots[t].r, spots[t].c, spots[t].ch),
                    448'(act), 448'(req));
      end
    end
  endtask

  initial begin
    spots[0] = '{0, 0, 0, 0, '{0, 0, 0, 0, 1, 2, 0, 5, 6}};
    spots[1] = '{0, 3, 3, 0, '{11, 12, 0, 15, 16, 0, 0, 0, 0}};
    spots[2] = '{0, 1, 2, 0, '{2, 3, 4, 6, 7, 8, 10, 11, 12}};
    spots[3] = '{0, 0, 3, 0, '{0, 0, 0, 3, 4, 0, 7, 8, 0}};
    spots[4] = '{0, 3, 0, 0, '{0, 9, 10, 0, 13, 14, 0, 0, 0}};
    spots[5] = '{1, 2, 2, 0, '{6, 7, 8, 10, 11, 12, 14, 15, 16}};
    spots[6] = '{1, 0, 2, 0, '{0, 0, 0, 2, 3, 4, 6, 7, 8}};
    spots[7] = '{2, 1, 1, 0, '{1, 2, 3, 5, 6, 7, 9, 10, 11}};
    spots[8] = '{2, 1, 1, 2, '{201, 202, 203, 205, 206, 207, 209, 210, 211}};
    spots[9] = '{2, 0, 0, 1, '{0, 0, 0, 0, 101, 102, 0, 105, 106}};

    rst = 1'b1; startCmd = 1'b0; validIn = 1'b0; readyIn = 1'b0; dataIn = '0; sel = 0;
    repeat (3) @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checkOutput($sformatf("reset_state_%0d", s),
                  448'({oReady, oValid, oBusy, oDone, oRow, oCol, oWin}), 448'(0));
    end
    @(posedge clk); #1 rst = 1'b0;

    $display("[TB] full-rate frame");
    applyStimulus(0, 1'b0, 0, 0);
    checkFrame(0);
    checkSpots(0);

    $display("[TB] random downstream back-pressure");
    applyStimulus(0, 1'b1, 0, 0);
    checkFrame(0);
    checkSpots(0);

    $display("[TB] stride 2");
    applyStimulus(1, 1'b0, 0, 0);
    checkFrame(1);
    checkSpots(1);

    $display("[TB] three channels with input gaps");
    applyStimulus(2, 1'b0, 3, 0);
    checkFrame(2);
    checkSpots(2);

    $display("[TB] reset mid-frame then full frame");
    applyStimulus(0, 1'b0, 0, 7);
    checkOutput("valid_before_abort", 448'(oValid), 448'(1));
    rst = 1'b1;
    #1;
    checkOutput("abort_outputs_low", 448'({oValid, oReady, oBusy}), 448'(0));
    @(posedge clk); #1 rst = 1'b0;
    applyStimulus(0, 1'b0, 0, 0);
    checkFrame(0);
    checkSpots(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
